sram_burst_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_burst_arbiter_rr.sv | 43 ++++
 rtl/sram_burst_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM burst arbiter: FSM states, default
// widths and the idle levels of the macro control pins.
package sram_arb_pkg;

  localparam int DEF_N_ADDR = 11;
  localparam int DEF_N_DATA = 8;

  localparam logic SRAM_WE_IDLE = 1'b0;
  localparam logic SRAM_SE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_burst_arbiter_rr.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when the
// grant is actually accepted, so a stalled grant keeps its priority.
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q, last_d;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = owner_onehot(~last_q);
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    if (accept) begin
      last_d = grant[1];
    end else begin
      last_d = last_q;
    end
  end

  // Reset value 1 makes requester 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_burst_arbiter.sv
// Burst sequencer sharing a single-port SRAM macro between two requesters:
// arbitration, address/count sequencing, write streaming and read return.
module sram_burst_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_addr = DEF_N_ADDR,
  parameter int N_data = DEF_N_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd_valid,
  output logic [1:0]            cmd_ready,
  input  logic [2*N_addr-1:0]   cmd_addr,
  input  logic [2*N_addr-1:0]   cmd_len,
  input  logic [1:0]            cmd_we,
  input  logic [2*N_data-1:0]   wdata,
  input  logic [1:0]            wvalid,
  output logic [1:0]            wready,
  output logic [N_data-1:0]     rdata,
  output logic [1:0]            rvalid,
  output logic [1:0]            done,
  output logic                  busy,
  output logic [N_addr-1:0]     sram_addr,
  output logic [N_data-1:0]     sram_din,
  output logic                  sram_write_en,
  output logic                  sram_sense_en,
  input  logic [N_data-1:0]     sram_dout
);

  state_e state_q, state_d;
  logic owner_q, owner_d;
  logic [N_addr-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [N_addr-1:0] sram_addr_q, sram_addr_d;
  logic [N_data-1:0] sram_din_q, sram_din_d, rdata_q, rdata_d;
  logic sram_we_q, sram_we_d, sram_se_q, sram_se_d;
  logic rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
  logic [1:0] rvalid_q, rvalid_d, done_q, done_d;

  logic [1:0] grant_s;
  logic accept_s, owner_wvalid_s;
  logic [N_data-1:0] owner_wdata_s;
  logic [N_addr-1:0] addr_inc_s, cnt_dec_s;

  // No grant while done is showing, so bursts are separated by an idle cycle.
  assign accept_s = (state_q == ST_IDLE) && (done_q == 2'b00) && (cmd_valid != 2'b00);

  sram_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (cmd_valid),
    .accept (accept_s),
    .grant  (grant_s)
  );

  assign owner_wvalid_s = owner_q ? wvalid[1] : wvalid[0];
  assign owner_wdata_s  = owner_q ? wdata[2*N_data-1:N_data] : wdata[N_data-1:0];
  assign addr_inc_s     = addr_q + N_addr'(1);
  assign cnt_dec_s      = cnt_q - N_addr'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    sram_we_d   = SRAM_WE_IDLE;
    sram_se_d   = SRAM_SE_IDLE;
    rd_p1_d     = 1'b0;
    done_d      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d = grant_s[1];
          addr_d  = grant_s[1] ? cmd_addr[2*N_addr-1:N_addr] : cmd_addr[N_addr-1:0];
          cnt_d   = grant_s[1] ? cmd_len[2*N_addr-1:N_addr] : cmd_len[N_addr-1:0];
          state_d = (grant_s[1] ? cmd_we[1] : cmd_we[0]) ? ST_WRITE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (owner_wvalid_s) begin
          sram_addr_d = addr_q;
          sram_din_d  = owner_wdata_s;
          sram_we_d   = 1'b1;
          addr_d      = addr_inc_s;
          cnt_d       = cnt_dec_s;
          if (cnt_q == {N_addr{1'b0}}) begin
            done_d  = owner_onehot(owner_q);
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        sram_addr_d = addr_q;
        sram_se_d   = 1'b0;
        rd_p1_d     = 1'b1;
        addr_d      = addr_inc_s;
        cnt_d       = cnt_dec_s;
        if (cnt_q == {N_addr{1'b0}}) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        // Last word is in the return stage and nothing is behind it.
        if (rd_p2_q && !rd_p1_q) begin
          done_d  = owner_onehot(owner_q);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read return: sense cycle, then macro output cycle, then registered rdata.
  always_comb begin
    rd_p2_d  = rd_p1_q;
    rvalid_d = rd_p2_q ? owner_onehot(owner_q) : 2'b00;
    if (rd_p2_q) begin
      rdata_d = sram_dout;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      addr_q      <= {N_addr{1'b0}};
      cnt_q       <= {N_addr{1'b0}};
      sram_addr_q <= {N_addr{1'b0}};
      sram_din_q  <= {N_data{1'b0}};
      sram_we_q   <= SRAM_WE_IDLE;
      sram_se_q   <= SRAM_SE_IDLE;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      rdata_q     <= {N_data{1'b0}};
      rvalid_q    <= 2'b00;
      done_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      sram_we_q   <= sram_we_d;
      sram_se_q   <= sram_se_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready     = accept_s ? grant_s : 2'b00;
  assign wready        = (state_q == ST_WRITE) ? owner_onehot(owner_q) : 2'b00;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign done          = done_q;
  assign busy          = (state_q != ST_IDLE);
  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;
  assign sram_write_en = sram_we_q;
  assign sram_sense_en = sram_se_q;

endmodule
